// File: rtl/hqm_rcfwl_gclk_pccdu_dop_ctrl_pkg.sv
// Shared types and constants for the PCCDU DOP sync/enable sequencer.
package hqm_rcfwl_gclk_pccdu_dop_ctrl_pkg;

  typedef enum logic [1:0] {
    CS_OFF      = 2'd0,
    CS_WAIT_ON  = 2'd1,
    CS_ON       = 2'd2,
    CS_WAIT_OFF = 2'd3
  } ctrl_state_e;

  localparam int SYNC_PERIOD_MIN = 2;
  localparam int SYNC_PERIOD_MAX = 1024;

endpackage

// File: rtl/hqm_rcfwl_gclk_pccdu_sync_cnt.sv
// Sync period counter: produces the transition boundary strobe and the
// registered single-cycle divider sync pulse.
module hqm_rcfwl_gclk_pccdu_sync_cnt
  import hqm_rcfwl_gclk_pccdu_dop_ctrl_pkg::*;
#(
  parameter int SYNC_PERIOD = 36
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_en,
  input  logic fscan_mode,
  output logic bnd,
  output logic div_sync
);

  localparam int CNT_W = $clog2(SYNC_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYNC_PERIOD - 1);

  logic [CNT_W-1:0] cnt;
  logic             run;
  logic             cnt_zero;

  assign run      = sync_en & ~fscan_mode;
  assign cnt_zero = (cnt == '0);

  // Without running sync the dividers are unaligned, so every edge is a boundary.
  assign bnd = ~run | cnt_zero;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      div_sync <= 1'b0;
    end else begin
      div_sync <= run & cnt_zero;
      if (!run || cnt == CNT_LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hqm_rcfwl_gclk_pccdu_dop_ctrl.sv
// DOP sequencer: periodic divider sync plus clock enable gated at sync
// boundaries under a level req/ack handshake, with scan override.
module hqm_rcfwl_gclk_pccdu_dop_ctrl
  import hqm_rcfwl_gclk_pccdu_dop_ctrl_pkg::*;
#(
  parameter int SYNC_PERIOD = 36
) (
  input  logic       fdop_preclk_grid,
  input  logic       fdop_preclk_rst,
  input  logic       sync_en,
  input  logic       clk_req,
  input  logic       fscan_mode,
  input  logic       fscan_byp_clken,
  output logic       fdop_preclk_div_sync,
  output logic       fscan_dop_clken,
  output logic       clk_ack,
  output logic [1:0] ctrl_state
);

  localparam logic [1:0] ST_OFF      = 2'(CS_OFF);
  localparam logic [1:0] ST_WAIT_ON  = 2'(CS_WAIT_ON);
  localparam logic [1:0] ST_ON       = 2'(CS_ON);
  localparam logic [1:0] ST_WAIT_OFF = 2'(CS_WAIT_OFF);

  generate
    if (SYNC_PERIOD < SYNC_PERIOD_MIN || SYNC_PERIOD > SYNC_PERIOD_MAX) begin : g_bad_period
      $error("SYNC_PERIOD out of range 2..1024");
    end
  endgenerate

  logic       bnd;
  logic       clken_q;
  logic [1:0] state_q;

  hqm_rcfwl_gclk_pccdu_sync_cnt #(
    .SYNC_PERIOD (SYNC_PERIOD)
  ) u_sync_cnt (
    .clk        (fdop_preclk_grid),
    .rst        (fdop_preclk_rst),
    .sync_en    (sync_en),
    .fscan_mode (fscan_mode),
    .bnd        (bnd),
    .div_sync   (fdop_preclk_div_sync)
  );

  // Enable only changes on a boundary edge so DOPs re-align and ungate together.
  always_ff @(posedge fdop_preclk_grid or posedge fdop_preclk_rst) begin
    if (fdop_preclk_rst) begin
      state_q <= ST_OFF;
      clken_q <= 1'b0;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (clk_req) state_q <= ST_WAIT_ON;
        end
        ST_WAIT_ON: begin
          if (!clk_req) begin
            state_q <= ST_OFF;
          end else if (bnd) begin
            state_q <= ST_ON;
            clken_q <= 1'b1;
          end
        end
        ST_ON: begin
          if (!clk_req) state_q <= ST_WAIT_OFF;
        end
        default: begin
          if (clk_req) begin
            state_q <= ST_ON;
          end else if (bnd) begin
            state_q <= ST_OFF;
            clken_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign clk_ack         = clken_q;
  assign ctrl_state      = state_q;
  assign fscan_dop_clken = fscan_mode ? fscan_byp_clken : clken_q;

endmodule

// File: tb/tb_hqm_rcfwl_gclk_pccdu_dop_ctrl.sv
// Scoreboard bench: a cycle model built from the handshake rules pushes
// expectations at each edge; a monitor pops and compares on the falling edge.
module tb_hqm_rcfwl_gclk_pccdu_dop_ctrl;

  localparam int P = 36;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sync_en = 1'b0;
  logic       clk_req = 1'b0;
  logic       scan = 1'b0;
  logic       byp = 1'b0;
  logic       div_sync;
  logic       dop_clken;
  logic       clk_ack;
  logic [1:0] ctrl_state;

  hqm_rcfwl_gclk_pccdu_dop_ctrl #(.SYNC_PERIOD(P)) dut (
    .fdop_preclk_grid     (clk),
    .fdop_preclk_rst      (rst),
    .sync_en              (sync_en),
    .clk_req              (clk_req),
    .fscan_mode           (scan),
    .fscan_byp_clken      (byp),
    .fdop_preclk_div_sync (div_sync),
    .fscan_dop_clken      (dop_clken),
    .clk_ack              (clk_ack),
    .ctrl_state           (ctrl_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       sync;
    logic       ack;
    logic [1:0] st;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the enable follows the request once the request has differed
  // from it on two consecutive sampled edges, the later one on a boundary.
  bit m_en, m_prev, m_run, m_bnd;
  int run_len;

  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      m_en = 0; m_prev = 0; run_len = 0;
      e = '0;
    end else begin
      m_run  = sync_en && !scan;
      m_bnd  = !m_run || (run_len % P == 0);
      e.sync = m_run && (run_len % P == 0);
      run_len = m_run ? run_len + 1 : 0;
      if (m_bnd && (clk_req != m_en) && (m_prev != m_en)) m_en = clk_req;
      m_prev = clk_req;
      e.ack = m_en;
      e.st  = {m_en, m_prev != m_en};
    end
    q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("div_sync", 32'(div_sync), 32'(e.sync));
      check("clk_ack", 32'(clk_ack), 32'(e.ack));
      check("ctrl_state", 32'(ctrl_state), 32'(e.st));
      check("dop_clken", 32'(dop_clken), 32'(scan ? byp : e.ack));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    tick(3);
    check("rst_sync", 32'(div_sync), 0);
    check("rst_ack", 32'(clk_ack), 0);
    check("rst_clken", 32'(dop_clken), 0);
    scan = 1; byp = 1; #1;
    check("rst_scan_clken", 32'(dop_clken), 1);
    scan = 0; byp = 0;

    // Periodic sync and request/ack through boundaries.
    rst = 0; tick(2);
    sync_en = 1; tick(5);
    clk_req = 1; tick(80);
    clk_req = 0; tick(80);
    clk_req = 1; tick(3);
    clk_req = 0; tick(50);
    clk_req = 1; tick(80);
    clk_req = 0; tick(2);
    clk_req = 1; tick(60);

    // Free-running dividers: transitions apply in two cycles.
    clk_req = 0; sync_en = 0; tick(5);
    clk_req = 1; tick(1);
    check("nosync_ack_1cyc", 32'(clk_ack), 0);
    tick(1);
    check("nosync_ack_2cyc", 32'(clk_ack), 1);
    clk_req = 0; tick(1);
    check("nosync_off_1cyc", 32'(clk_ack), 1);
    tick(1);
    check("nosync_off_2cyc", 32'(clk_ack), 0);

    // Scan override.
    sync_en = 1; scan = 1; clk_req = 1;
    for (int i = 0; i < 12; i++) begin
      byp = 1'($urandom); #1;
      check("scan_clken", 32'(dop_clken), 32'(byp));
      check("scan_sync", 32'(div_sync), 0);
      tick(1);
    end
    scan = 0; tick(40);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) sync_en = ~sync_en;
      if ($urandom_range(0, 299) == 0) scan = ~scan;
      if ($urandom_range(0, 24) == 0) clk_req = ~clk_req;
      byp = 1'($urandom);
      tick(1);
    end

    // Reset in WAIT_OFF at count 20.
    sync_en = 1; scan = 0; clk_req = 1; tick(80);
    begin
      int guard = 0;
      while ((run_len % P) != 19 && guard < 200) begin
        tick(1);
        guard++;
      end
      check("align_cnt19", 32'(run_len % P), 19);
    end
    clk_req = 0; tick(1);
    check("pre_rst_state", 32'(ctrl_state), 3);
    rst = 1; #1;
    check("rst_mid_sync", 32'(div_sync), 0);
    check("rst_mid_ack", 32'(clk_ack), 0);
    check("rst_mid_clken", 32'(dop_clken), 0);
    check("rst_mid_state", 32'(ctrl_state), 0);
    tick(3);
    sync_en = 0; rst = 0; tick(3);
    sync_en = 1; tick(80);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
